// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared state encoding and default widths for mem_arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t DATA = 2'd1;
    localparam state_t INST = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_arb_timer.sv
// ============================================================================
//  Module      : mem_arb_timer
//  Description : Clear/increment watchdog; flags the cycle whose increment
//                would reach TIMEOUT.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Abort happens on the edge where the count would become TIMEOUT.
    assign expired_o = inc_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates one single-port memory between IF and MEM stages,
//                data has fixed priority. Optional watchdog: MEM_ARB_TIMEOUT_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic busy;
    logic grant;
    logic done;
    logic abort;
    logic expired;

    assign busy  = (state_q == DATA) || (state_q == INST);
    assign grant = (state_q == IDLE) && (d_req_i || if_req_i);
    assign done  = busy && mem_ack_i;
    // A real ack in the same cycle as expiry takes precedence.
    assign abort = busy && !mem_ack_i && expired;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (grant),
        .inc_i     (busy),
        .expired_o (expired)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT == 0);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req_i) begin
                    state_d = DATA;
                end else if (if_req_i) begin
                    state_d = INST;
                end
            end
            DATA, INST: begin
                if (done || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (d_req_i) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                end else if (if_req_i) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                end
            end
            DATA: begin
                if (done || abort) begin
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = done ? mem_rdata_i : '0;
                    end
                    if (abort) begin
                        err_d = 1'b1;
                    end
                end
            end
            INST: begin
                if (done || abort) begin
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = done ? mem_rdata_i : '0;
                    if (abort) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter (TIMEOUT = 8).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              d_req_i = 1'b0;
    logic              d_we_i = 1'b0;
    logic [ADDR_W-1:0] d_addr_i = '0;
    logic [DATA_W-1:0] d_wdata_i = '0;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              mem_ack_i = 1'b0;
    logic              stall_o;
    logic              err_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_ack_o     (d_ack_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_acks", 64'({if_ack_o, d_ack_o}), 64'd0);
        chk("rst_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst_i = 1'b1;
        tick();

        // 1. Fetch only
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        #1;
        chk("t1_stall_pre", 64'(stall_o), 64'd1);
        tick();
        chk("t1_mem_req", 64'(mem_req_o), 64'd1);
        chk("t1_addr", 64'(mem_addr_o), 64'h10);
        chk("t1_we", 64'(mem_we_o), 64'd0);
        tick();
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h00A00093;
        tick();
        mem_ack_i = 1'b0;
        chk("t1_if_ack", 64'(if_ack_o), 64'd1);
        chk("t1_if_rdata", 64'(if_rdata_o), 64'h00A00093);
        chk("t1_stall_ack", 64'(stall_o), 64'd0);
        chk("t1_req_drop", 64'(mem_req_o), 64'd0);
        chk("t1_d_ack", 64'(d_ack_o), 64'd0);
        if_req_i = 1'b0;
        tick();
        chk("t1_if_ack_pulse", 64'(if_ack_o), 64'd0);
        chk("t1_rdata_hold", 64'(if_rdata_o), 64'h00A00093);

        // 2. Collision: data wins, then one IDLE cycle, then fetch
        if_req_i  = 1'b1;
        if_addr_i = 32'h80;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h40;
        tick();
        chk("t2_addr_data", 64'(mem_addr_o), 64'h40);
        chk("t2_stall_a", 64'(stall_o), 64'd1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h11112222;
        tick();
        mem_ack_i = 1'b0;
        chk("t2_d_ack", 64'(d_ack_o), 64'd1);
        chk("t2_d_rdata", 64'(d_rdata_o), 64'h11112222);
        chk("t2_if_ack_none", 64'(if_ack_o), 64'd0);
        chk("t2_stall_b", 64'(stall_o), 64'd1);
        chk("t2_idle_gap", 64'(mem_req_o), 64'd0);
        d_req_i = 1'b0;
        tick();
        chk("t2_inst_req", 64'(mem_req_o), 64'd1);
        chk("t2_inst_addr", 64'(mem_addr_o), 64'h80);
        chk("t2_inst_we", 64'(mem_we_o), 64'd0);
        chk("t2_stall_c", 64'(stall_o), 64'd1);
        chk("t2_d_ack_pulse", 64'(d_ack_o), 64'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h33334444;
        tick();
        mem_ack_i = 1'b0;
        chk("t2_if_ack", 64'(if_ack_o), 64'd1);
        chk("t2_if_rdata", 64'(if_rdata_o), 64'h33334444);
        chk("t2_d_rdata_hold", 64'(d_rdata_o), 64'h11112222);
        chk("t2_stall_end", 64'(stall_o), 64'd0);
        if_req_i = 1'b0;
        tick();

        // Stray memory ack while idle
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBAD0BAD0;
        tick();
        mem_ack_i = 1'b0;
        chk("idle_ack_acks", 64'({if_ack_o, d_ack_o}), 64'd0);
        chk("idle_ack_req", 64'(mem_req_o), 64'd0);
        chk("idle_ack_rdata", 64'(d_rdata_o), 64'h11112222);

        // 3. Store
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h44;
        d_wdata_i = 32'hDEADBEEF;
        tick();
        chk("t3_we", 64'(mem_we_o), 64'd1);
        chk("t3_addr", 64'(mem_addr_o), 64'h44);
        chk("t3_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
        d_addr_i  = 32'h0;
        d_wdata_i = 32'h0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("t3_wdata_latched", 64'(mem_wdata_o), 64'hDEADBEEF);
        tick();
        mem_ack_i = 1'b0;
        chk("t3_d_ack", 64'(d_ack_o), 64'd1);
        chk("t3_rdata_keep", 64'(d_rdata_o), 64'h11112222);
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        tick();

        // 6. Requester drops before ack
        d_req_i  = 1'b1;
        d_addr_i = 32'h48;
        tick();
        chk("t6_req", 64'(mem_req_o), 64'd1);
        tick();
        d_req_i = 1'b0;
        tick();
        chk("t6_req_held", 64'(mem_req_o), 64'd1);
        chk("t6_addr_held", 64'(mem_addr_o), 64'h48);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h00000055;
        tick();
        mem_ack_i = 1'b0;
        chk("t6_d_ack", 64'(d_ack_o), 64'd1);
        chk("t6_d_rdata", 64'(d_rdata_o), 64'h55);
        tick();
        chk("t6_d_ack_once", 64'(d_ack_o), 64'd0);
        chk("t6_idle", 64'(mem_req_o), 64'd0);

        // 5. Memory never acks
        d_req_i  = 1'b1;
        d_addr_i = 32'h50;
        tick();
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            chk("t5_wait_req", 64'(mem_req_o), 64'd1);
            chk("t5_wait_ack", 64'(d_ack_o), 64'd0);
            tick();
        end
        chk("t5_last_req", 64'(mem_req_o), 64'd1);
        tick();
        chk("t5_abort_ack", 64'(d_ack_o), 64'd1);
        chk("t5_abort_rdata", 64'(d_rdata_o), 64'd0);
        chk("t5_err", 64'(err_o), 64'd1);
        chk("t5_req_drop", 64'(mem_req_o), 64'd0);
        d_req_i = 1'b0;
        tick();
        tick();
        chk("t5_err_sticky", 64'(err_o), 64'd1);
        chk("t5_ack_pulse", 64'(d_ack_o), 64'd0);
`else
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            chk("t5_wait_req", 64'(mem_req_o), 64'd1);
            chk("t5_wait_ack", 64'(d_ack_o), 64'd0);
            chk("t5_no_err", 64'(err_o), 64'd0);
            tick();
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h00000077;
        tick();
        mem_ack_i = 1'b0;
        chk("t5_late_ack", 64'(d_ack_o), 64'd1);
        chk("t5_late_rdata", 64'(d_rdata_o), 64'h77);
        d_req_i = 1'b0;
        tick();
`endif

        // 4. Reset in the middle of a data access
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h4C;
        tick();
        chk("t4_req_before", 64'(mem_req_o), 64'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t4_req_async", 64'(mem_req_o), 64'd0);
        chk("t4_addr_async", 64'(mem_addr_o), 64'd0);
        chk("t4_rdata_async", 64'(d_rdata_o), 64'd0);
        chk("t4_err_async", 64'(err_o), 64'd0);
        d_req_i = 1'b0;
        tick();
        chk("t4_no_ack", 64'(d_ack_o), 64'd0);
        #3;
        rst_i = 1'b1;
        tick();
        chk("t4_idle_req", 64'(mem_req_o), 64'd0);
        chk("t4_idle_ack", 64'(d_ack_o), 64'd0);
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        tick();
        chk("t4_regrant", 64'(mem_addr_o), 64'h20);
        if_req_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
